br_predict_unit: RTL and testbench
==================================

// Module: br_predict_unit
// PURPOSE
//  Branch resolution and prediction for the RV32I pipeline. Generalises the EX-stage branch decision.
//  - Resolves all six B-type conditions (BEQ/BNE/BLT/BGE/BLTU/BGEU) plus jumps directly from the rs1/rs2 operands.
//  - Keeps a DEPTH-entry table of 2-bit saturating counters (BHT), indexed by PC, which IF reads for a prediction.
//  - Flags mispredicts to the hazard unit for flushing.
// PARAMETERS
//  WIDTH    32  data/PC width in bits
//  DEPTH    64  BHT entries; power of two, >=2
//  IDX_LSB  2   lowest PC bit used for the index (word-aligned PCs)
// PORTS
//  clk           in   1      clock, rising edge
//  reset         in   1      synchronous, active-high
//  if_pc         in   WIDTH  fetch PC used for the lookup
//  if_pred_taken out  1      prediction for if_pc (counter MSB); combinational
//  ex_valid      in   1      EX slot holds a real instruction
//  ex_pc         in   WIDTH  PC of the EX instruction (update index)
//  ex_funct3     in   3      branch condition select
//  ex_branch     in   1      EX instruction is B-type
//  ex_jump       in   1      EX instruction is JAL/JALR
//  ex_rs1        in   WIDTH  operand 1
//  ex_rs2        in   WIDTH  operand 2
//  ex_pred_taken in   1      prediction carried down the pipe from IF
//  ex_taken      out  1      resolved outcome; combinational
//  mispredict    out  1      registered flush request, 1 cycle after the EX resolution
//  illegal_cond  out  1      combinational: ex_valid & ex_branch & funct3 in {010, 011}
// BEHAVIOUR
//  - Index: idx = pc[IDX_LSB +: $clog2(DEPTH)], for both the lookup and the update.
//  - Conditions:
//    - 000 eq, 001 ne.
//    - 100 signed <, 101 signed >=.
//    - 110 unsigned <, 111 unsigned >=.
//    - 010/011: not taken and illegal_cond=1.
//  - ex_taken = ex_valid & (ex_jump | (ex_branch & cond)). ex_jump dominates when both are set.
//  - Compare is full WIDTH. Signed compare uses $signed, with no subtraction and no overflow artefacts.
//  - Update, at the clock edge when ex_valid & ex_branch & !illegal_cond:
//    - taken: counter +1, saturating at 11.
//    - not taken: counter -1, saturating at 00.
//    - Jumps never update the BHT.
//  - States per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//  - mispredict register:
//    - Next value = ex_valid & (ex_branch|ex_jump) & (ex_taken != ex_pred_taken).
//    - Asserted for exactly one cycle per resolved slot. Back-to-back mispredicts give back-to-back pulses.
//  - Read/write collision: when if_pc and ex_pc map to the same index in one cycle, the lookup returns the OLD counter. There is no bypass.
//  - Aliasing: different PCs with the same index share an entry. This is intended.
//  - Reset:
//    - All counters go to 01 in the same cycle.
//    - mispredict=0.
//    - Combinational outputs follow their inputs; if_pred_taken reads 0 after reset.
//    - A reset asserted mid-stream discards any update pending that cycle; reset wins over the update.
// CONFIGURATION
//  - Macro BR_STATS_EN adds three outputs, each a 32-bit counter incremented at the update edge and wrapping at 2^32:
//    - stat_branches: resolved branches+jumps.
//    - stat_taken: taken ones.
//    - stat_mispred: mispredicts.
//  - All three are cleared by reset.
//  - Without BR_STATS_EN the ports and registers are absent, and the rest of the behaviour is unchanged.
// STRUCTURE
//  - Package br_pkg holds:
//    - typedef enum logic [2:0] br_cond_e (BEQ..BGEU values above).
//    - typedef enum logic [1:0] bht_state_e (SNT, WNT, WT, ST).
//    - function sat_update(bht_state_e, logic taken).
//  - Sub-module br_compare: purely combinational condition evaluation (rs1, rs2, funct3 -> cond, illegal).
//  - The BHT array and the mispredict register stay in the top.
// TESTING
//  1. Reset, then if_pc=0x100 -> if_pred_taken=0. Read every index -> 01.
//  2. BLT rs1=0xFFFFFFFF, rs2=1 -> ex_taken=1. BLTU with the same operands -> 0.
//     BGE 5,5 -> 1. BNE 7,7 -> 0.
//  3. PC 0x40: three taken BEQs -> counter 01→10→11→11 (saturates).
//     Then if_pred_taken=1. Two not-taken -> 11→10→01, then pred=0.
//  4. ex_pred_taken=0 on a taken branch -> mispredict=1 exactly on the next cycle, only one cycle.
//     JAL with pred=1 -> no mispredict.
//  5. if_pc=ex_pc=0x80 on the update cycle -> old prediction that cycle, new value the cycle after.
//     Also: reset asserted on the update edge -> entry is 01.
//  6. funct3=010 with ex_branch -> illegal_cond=1, ex_taken=0, BHT unchanged.
//     With BR_STATS_EN: 10 branches, 4 taken, 3 mispredicts -> 10/4/3.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types for the branch resolution / prediction unit: condition codes,
// BHT counter states and the saturating counter update.
package br_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_cond_e;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_e;

    // Move one step toward the observed outcome, holding at the strong ends.
    function automatic bht_state_e sat_update(input bht_state_e state, input logic taken);
        logic [1:0] v;
        v = state;
        if (taken) begin
            if (state != ST) v = v + 2'd1;
        end else begin
            if (state != SNT) v = v - 2'd1;
        end
        return bht_state_e'(v);
    endfunction

endpackage

// File: rtl/br_compare.sv
// Combinational RV32I branch condition evaluation from the raw operands.
// funct3 codes 010/011 are not branch conditions and report illegal.
module br_compare
    import br_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [2:0]       funct3,
    output logic             cond,
    output logic             illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     cond = (rs1 == rs2);
            BNE:     cond = (rs1 != rs2);
            BLT:     cond = ($signed(rs1) <  $signed(rs2));
            BGE:     cond = ($signed(rs1) >= $signed(rs2));
            BLTU:    cond = (rs1 <  rs2);
            BGEU:    cond = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/br_predict_unit.sv
// EX-stage branch resolution, 2-bit BHT predictor and registered mispredict flag.
// Optional BR_STATS_EN adds 32-bit branch / taken / mispredict counters.
module br_predict_unit
    import br_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 64,
    parameter int IDX_LSB = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [2:0]       ex_funct3,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [WIDTH-1:0] ex_rs1,
    input  logic [WIDTH-1:0] ex_rs2,
    input  logic             ex_pred_taken,
    output logic             ex_taken,
    output logic             mispredict,
    output logic             illegal_cond
`ifdef BR_STATS_EN
    ,
    output logic [31:0]      stat_branches,
    output logic [31:0]      stat_taken,
    output logic [31:0]      stat_mispred
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_cond;
    logic             w_illegal;
    logic             w_resolved;
    logic             w_bht_we;
    logic             w_mispredict_nxt;
    logic             w_unused_pc;

    bht_state_e       r_bht [DEPTH];
    logic             r_mispredict;

    br_compare #(
        .WIDTH (WIDTH)
    ) u_compare (
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .funct3  (ex_funct3),
        .cond    (w_cond),
        .illegal (w_illegal)
    );

    assign w_if_idx = if_pc[IDX_LSB +: IDX_W];
    assign w_ex_idx = ex_pc[IDX_LSB +: IDX_W];
    assign w_unused_pc = ^{if_pc, ex_pc};

    assign illegal_cond     = ex_valid & ex_branch & w_illegal;
    assign ex_taken         = ex_valid & (ex_jump | (ex_branch & w_cond));
    assign w_resolved       = ex_valid & (ex_branch | ex_jump);
    assign w_bht_we         = ex_valid & ex_branch & ~w_illegal;
    assign w_mispredict_nxt = w_resolved & (ex_taken != ex_pred_taken);

    // Lookup reads the stored counter only; a same-index update lands next cycle.
    assign if_pred_taken = r_bht[w_if_idx][1];
    assign mispredict    = r_mispredict;

    always_ff @(posedge clk) begin
        // NOTE: the whole table is reset because every entry must start at weak-not-taken.
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bht[i] <= WNT;
            end
            r_mispredict <= 1'b0;
        end else begin
            // NOTE: state is written with <= so every register samples pre-edge values.
            if (w_bht_we) begin
                r_bht[w_ex_idx] <= sat_update(r_bht[w_ex_idx], ex_taken);
            end
            r_mispredict <= w_mispredict_nxt;
        end
    end

`ifdef BR_STATS_EN
    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_taken;
    logic [31:0] r_stat_mispred;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_branches <= '0;
            r_stat_taken    <= '0;
            r_stat_mispred  <= '0;
        end else begin
            if (w_resolved)       r_stat_branches <= r_stat_branches + 32'd1;
            if (ex_taken)         r_stat_taken    <= r_stat_taken + 32'd1;
            if (w_mispredict_nxt) r_stat_mispred  <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_branches = r_stat_branches;
    assign stat_taken    = r_stat_taken;
    assign stat_mispred  = r_stat_mispred;
`endif

endmodule

// File: tb/tb_br_predict_unit.sv
// Directed self-checking bench for br_predict_unit (optionally with BR_STATS_EN).
module tb_br_predict_unit;
    import br_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [2:0]  ex_funct3;
    logic        ex_branch;
    logic        ex_jump;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic        ex_pred_taken;
    logic        ex_taken;
    logic        mispredict;
    logic        illegal_cond;
`ifdef BR_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_taken;
    logic [31:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    br_predict_unit #(
        .WIDTH   (32),
        .DEPTH   (64),
        .IDX_LSB (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_funct3     (ex_funct3),
        .ex_branch     (ex_branch),
        .ex_jump       (ex_jump),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_pred_taken (ex_pred_taken),
        .ex_taken      (ex_taken),
        .mispredict    (mispredict),
        .illegal_cond  (illegal_cond)
`ifdef BR_STATS_EN
        ,
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken),
        .stat_mispred  (stat_mispred)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        v;
        logic        br;
        logic        jmp;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp;
    } cmp_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                          input logic br, input logic jmp, input logic [31:0] a,
                          input logic [31:0] b, input logic pred);
        ex_valid      = v;
        ex_pc         = pc;
        ex_funct3     = f3;
        ex_branch     = br;
        ex_jump       = jmp;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pred_taken = pred;
    endtask

    task automatic idle();
        set_ex(1'b0, 32'h0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // A taken (equal operands) or not-taken BEQ at pc, left on the bus for one edge.
    task automatic beq_step(input logic [31:0] pc, input logic taken, input logic pred);
        set_ex(1'b1, pc, BEQ, 1'b1, 1'b0, 32'h5, taken ? 32'h5 : 32'h6, pred);
        tick();
        idle();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        if_pc = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        total++;
        if (mispredict !== 1'b0) begin
            bad++;
            $display("FAIL reset_mispredict got=%0b want=0", mispredict);
        end
        if_pc = 32'h100;
        #1;
        total++;
        if (if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL reset_pred_0x100 got=%0b want=0", if_pred_taken);
        end
        for (int i = 0; i < 64; i++) begin
            if_pc = i * 4;
            #1;
            total++;
            if (if_pred_taken !== 1'b0) begin
                bad++;
                $display("FAIL reset_pred_idx%0d got=%0b want=0", i, if_pred_taken);
            end
        end
    endtask

    task automatic test_compare();
        cmp_vec_t vecs [14];
        vecs[0]  = '{"blt_neg",       1'b1, 1'b1, 1'b0, BLT,  32'hFFFF_FFFF, 32'h1,         1'b1};
        vecs[1]  = '{"bltu_big",      1'b1, 1'b1, 1'b0, BLTU, 32'hFFFF_FFFF, 32'h1,         1'b0};
        vecs[2]  = '{"bge_eq",        1'b1, 1'b1, 1'b0, BGE,  32'h5,         32'h5,         1'b1};
        vecs[3]  = '{"bne_eq",        1'b1, 1'b1, 1'b0, BNE,  32'h7,         32'h7,         1'b0};
        vecs[4]  = '{"beq_eq",        1'b1, 1'b1, 1'b0, BEQ,  32'h7,         32'h7,         1'b1};
        vecs[5]  = '{"bgeu_small",    1'b1, 1'b1, 1'b0, BGEU, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{"blt_minmax",    1'b1, 1'b1, 1'b0, BLT,  32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
        vecs[7]  = '{"bge_maxmin",    1'b1, 1'b1, 1'b0, BGE,  32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[8]  = '{"bltu_maxmin",   1'b1, 1'b1, 1'b0, BLTU, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1};
        vecs[9]  = '{"beq_invalid",   1'b0, 1'b1, 1'b0, BEQ,  32'h7,         32'h7,         1'b0};
        vecs[10] = '{"jal",           1'b1, 1'b0, 1'b1, BNE,  32'h7,         32'h7,         1'b1};
        vecs[11] = '{"jump_dominates",1'b1, 1'b1, 1'b1, BNE,  32'h7,         32'h7,         1'b1};
        vecs[12] = '{"bne_diff",      1'b1, 1'b1, 1'b0, BNE,  32'h1,         32'h2,         1'b1};
        vecs[13] = '{"beq_msb_diff",  1'b1, 1'b1, 1'b0, BEQ,  32'h8000_0001, 32'h1,         1'b0};
        for (int i = 0; i < 14; i++) begin
            set_ex(vecs[i].v, 32'h200, vecs[i].f3, vecs[i].br, vecs[i].jmp,
                   vecs[i].a, vecs[i].b, vecs[i].exp);
            #2;
            total++;
            if (ex_taken !== vecs[i].exp || illegal_cond !== 1'b0) begin
                bad++;
                $display("FAIL cmp_%s taken=%0b illegal=%0b want taken=%0b illegal=0",
                         vecs[i].name, ex_taken, illegal_cond, vecs[i].exp);
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_bht_train();
        logic exp_pred [5];
        logic taken_seq [5];
        taken_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_pred  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        if_pc = 32'h40;
        #1;
        total++;
        if (if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL train_init got=%0b want=0", if_pred_taken);
        end
        for (int i = 0; i < 5; i++) begin
            beq_step(32'h40, taken_seq[i], taken_seq[i]);
            total++;
            if (if_pred_taken !== exp_pred[i]) begin
                bad++;
                $display("FAIL train_step%0d got=%0b want=%0b", i, if_pred_taken, exp_pred[i]);
            end
        end
    endtask

    task automatic test_mispredict();
        idle();
        tick();
        set_ex(1'b1, 32'h300, BEQ, 1'b1, 1'b0, 32'h9, 32'h9, 1'b0);
        #1;
        total++;
        if (ex_taken !== 1'b1 || mispredict !== 1'b0) begin
            bad++;
            $display("FAIL mis_before taken=%0b mis=%0b want taken=1 mis=0", ex_taken, mispredict);
        end
        tick();
        idle();
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++;
            $display("FAIL mis_pulse got=%0b want=1", mispredict);
        end
        tick();
        total++;
        if (mispredict !== 1'b0) begin
            bad++;
            $display("FAIL mis_one_cycle got=%0b want=0", mispredict);
        end
        // Back-to-back: taken with pred 0, then not-taken with pred 1.
        set_ex(1'b1, 32'h300, BEQ, 1'b1, 1'b0, 32'h9, 32'h9, 1'b0);
        tick();
        set_ex(1'b1, 32'h304, BEQ, 1'b1, 1'b0, 32'h9, 32'h8, 1'b1);
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++;
            $display("FAIL mis_b2b_first got=%0b want=1", mispredict);
        end
        tick();
        idle();
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++;
            $display("FAIL mis_b2b_second got=%0b want=1", mispredict);
        end
        tick();
        total++;
        if (mispredict !== 1'b0) begin
            bad++;
            $display("FAIL mis_b2b_end got=%0b want=0", mispredict);
        end
        set_ex(1'b1, 32'h308, BEQ, 1'b0, 1'b1, 32'h1, 32'h2, 1'b1);
        tick();
        idle();
        #1;
        total++;
        if (mispredict !== 1'b0) begin
            bad++;
            $display("FAIL mis_jal_pred1 got=%0b want=0", mispredict);
        end
        set_ex(1'b1, 32'h308, BEQ, 1'b0, 1'b1, 32'h1, 32'h2, 1'b0);
        tick();
        idle();
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++;
            $display("FAIL mis_jal_pred0 got=%0b want=1", mispredict);
        end
        set_ex(1'b1, 32'h30C, BLTU, 1'b1, 1'b0, 32'h1, 32'h2, 1'b1);
        tick();
        idle();
        #1;
        total++;
        if (mispredict !== 1'b0) begin
            bad++;
            $display("FAIL mis_correct got=%0b want=0", mispredict);
        end
        tick();
    endtask

    task automatic test_collision_and_reset();
        if_pc = 32'h80;
        set_ex(1'b1, 32'h80, BEQ, 1'b1, 1'b0, 32'h3, 32'h3, 1'b1);
        #1;
        total++;
        if (if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL collide_old got=%0b want=0", if_pred_taken);
        end
        tick();
        idle();
        #1;
        total++;
        if (if_pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL collide_new got=%0b want=1", if_pred_taken);
        end
        // Reset on the update edge must win over the update and the mispredict.
        if_pc = 32'hC0;
        beq_step(32'hC0, 1'b1, 1'b1);
        total++;
        if (if_pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL rst_pretrain got=%0b want=1", if_pred_taken);
        end
        set_ex(1'b1, 32'hC0, BEQ, 1'b1, 1'b0, 32'h3, 32'h3, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        total++;
        if (if_pred_taken !== 1'b0 || mispredict !== 1'b0) begin
            bad++;
            $display("FAIL rst_wins pred=%0b mis=%0b want pred=0 mis=0", if_pred_taken, mispredict);
        end
        if_pc = 32'h80;
        #1;
        total++;
        if (if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL rst_other_entry got=%0b want=0", if_pred_taken);
        end
        if_pc = 32'hC0;
        beq_step(32'hC0, 1'b1, 1'b1);
        total++;
        if (if_pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL rst_entry_is_wnt got=%0b want=1", if_pred_taken);
        end
    endtask

    task automatic test_illegal();
        if_pc = 32'h44;
        set_ex(1'b1, 32'h44, 3'b010, 1'b1, 1'b0, 32'h3, 32'h3, 1'b1);
        #1;
        total++;
        if (illegal_cond !== 1'b1 || ex_taken !== 1'b0) begin
            bad++;
            $display("FAIL ill_010 illegal=%0b taken=%0b want illegal=1 taken=0", illegal_cond, ex_taken);
        end
        tick();
        set_ex(1'b1, 32'h44, 3'b011, 1'b1, 1'b0, 32'h3, 32'h3, 1'b0);
        #1;
        total++;
        if (mispredict !== 1'b1) begin
            bad++;
            $display("FAIL ill_mispredict got=%0b want=1", mispredict);
        end
        total++;
        if (illegal_cond !== 1'b1 || ex_taken !== 1'b0) begin
            bad++;
            $display("FAIL ill_011 illegal=%0b taken=%0b want illegal=1 taken=0", illegal_cond, ex_taken);
        end
        tick();
        set_ex(1'b1, 32'h44, 3'b010, 1'b0, 1'b0, 32'h3, 32'h3, 1'b0);
        #1;
        total++;
        if (illegal_cond !== 1'b0 || mispredict !== 1'b0) begin
            bad++;
            $display("FAIL ill_not_branch illegal=%0b mis=%0b want 0/0", illegal_cond, mispredict);
        end
        set_ex(1'b0, 32'h44, 3'b011, 1'b1, 1'b0, 32'h3, 32'h3, 1'b0);
        #1;
        total++;
        if (illegal_cond !== 1'b0) begin
            bad++;
            $display("FAIL ill_invalid got=%0b want=0", illegal_cond);
        end
        total++;
        if (if_pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL ill_bht_not_inc got=%0b want=0", if_pred_taken);
        end
        tick();
        beq_step(32'h44, 1'b1, 1'b1);
        total++;
        if (if_pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL ill_bht_not_dec got=%0b want=1", if_pred_taken);
        end
    endtask

`ifdef BR_STATS_EN
    task automatic test_stats();
        logic tk [10];
        logic pr [10];
        tk = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        pr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        total++;
        if (stat_branches !== 32'd0 || stat_taken !== 32'd0 || stat_mispred !== 32'd0) begin
            bad++;
            $display("FAIL stats_reset got=%0d/%0d/%0d want=0/0/0", stat_branches, stat_taken, stat_mispred);
        end
        for (int i = 0; i < 10; i++) begin
            set_ex(1'b1, 32'h500 + i * 4, BEQ, 1'b1, 1'b0, 32'h1, tk[i] ? 32'h1 : 32'h2, pr[i]);
            tick();
        end
        idle();
        tick();
        total++;
        if (stat_branches !== 32'd10 || stat_taken !== 32'd4 || stat_mispred !== 32'd3) begin
            bad++;
            $display("FAIL stats_count got=%0d/%0d/%0d want=10/4/3", stat_branches, stat_taken, stat_mispred);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        if_pc = 32'h0;
        idle();
        test_reset();
        test_compare();
        test_bht_train();
        test_mispredict();
        test_collision_and_reset();
        test_illegal();
`ifdef BR_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
